// File: rtl/switch_scan_encoder.sv
// switch_scan_encoder: scan master and debounced make/break encoder for a 10-column active-low switch matrix
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   scan_en    1 = scanning runs, 0 = scan frozen on the current column
//   col_bcd    column index (0..9) to the BCD-to-decimal column decoder
//   row_n      active-low row returns for the selected column
//   key_valid  event register holds an undelivered event
//   key_ready  consumer accepts the event while key_valid is high
//   key_code   {1'b0, row[2:0], col[3:0]}
//   key_press  1 = make, 0 = break
//   key_map    debounced switch state, bit row*10+col, 1 = closed
module switch_scan_encoder #(
  parameter int ROWS           = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 scan_en,
  output logic [3:0]           col_bcd,
  input  logic [ROWS-1:0]      row_n,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [7:0]           key_code,
  output logic                 key_press,
  output logic [ROWS*10-1:0]   key_map
);
  localparam int N  = ROWS * 10;
  localparam int IW = $clog2(N);
  localparam logic [2:0] SAT = 3'(DEBOUNCE_SCANS);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, ADVANCE} state_t;
  state_t          r_state;
  logic [7:0]      r_settle;
  logic [3:0]      r_col;
  logic [2:0]      r_cnt [N];
  logic [N-1:0]    r_map;
  logic            r_valid;
  logic [7:0]      r_code;
  logic            r_press;
  logic [IW-1:0]   w_idx [ROWS];
  logic [2:0]      w_cnt_next [ROWS];
  logic [IW-1:0]   w_win_idx;
  logic [2:0]      w_row;
  logic            w_issue;
  assign col_bcd   = r_col;
  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign key_press = r_press;
  assign key_map   = r_map;
  // Rows are walked high to low so the lowest saturated row is the last one written and wins.
  always_comb begin
    w_issue   = 1'b0;
    w_row     = '0;
    w_win_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      w_idx[r]      = IW'(r * 10) + IW'(r_col);
      w_cnt_next[r] = (~row_n[r] == r_map[w_idx[r]]) ? 3'd0 :
                      (r_cnt[w_idx[r]] == SAT) ? SAT : r_cnt[w_idx[r]] + 3'd1;
      if (w_cnt_next[r] == SAT) begin
        w_issue   = 1'b1;
        w_row     = 3'(r);
        w_win_idx = w_idx[r];
      end
    end
    // A blocked winner keeps its saturated count and retries on this column's next pass.
    w_issue = w_issue && scan_en && r_state == SAMPLE && (!r_valid || key_ready);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_settle <= '0;
      r_col    <= '0;
      r_map    <= '0;
      r_valid  <= 1'b0;
      r_code   <= '0;
      r_press  <= 1'b0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      if (r_valid && key_ready) r_valid <= 1'b0;
      if (!scan_en) r_state <= IDLE;
      else begin
        case (r_state)
          IDLE: begin
            r_state  <= SETTLE;
            r_settle <= '0;
          end
          SETTLE: begin
            r_state  <= (r_settle == 8'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
            r_settle <= (r_settle == 8'(SETTLE_CYCLES - 1)) ? 8'd0 : r_settle + 8'd1;
          end
          SAMPLE: begin
            r_state <= ADVANCE;
            for (int r = 0; r < ROWS; r++)
              r_cnt[w_idx[r]] <= (w_issue && w_row == 3'(r)) ? 3'd0 : w_cnt_next[r];
            if (w_issue) begin
              r_map[w_win_idx] <= ~r_map[w_win_idx];
              r_valid          <= 1'b1;
              r_code           <= {1'b0, w_row, r_col};
              r_press          <= ~r_map[w_win_idx];
            end
          end
          default: begin
            r_state <= SETTLE;
            r_col   <= (r_col == 4'd9) ? 4'd0 : r_col + 4'd1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_switch_scan_encoder.sv
// tb_switch_scan_encoder: directed bench for switch_scan_encoder with a modelled switch matrix
module tb_switch_scan_encoder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        key_ready = 1'b1;
  logic [3:0]  col_bcd;
  logic [3:0]  row_n;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        key_press;
  logic [39:0] key_map;
  logic [39:0] sw = '0;
  int n_chk = 0;
  int n_fail = 0;
  int n_make = 0;
  always #5 clk = ~clk;
  switch_scan_encoder dut (
    .clk(clk), .reset_n(reset_n), .scan_en(scan_en), .col_bcd(col_bcd), .row_n(row_n),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code), .key_press(key_press),
    .key_map(key_map)
  );
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      if (col_bcd < 4'd10) row_n[r] = !sw[r * 10 + int'(col_bcd)];
  end
  always @(posedge clk) if (key_valid && key_ready && key_press) n_make++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_valid(input int max, input logic [3:0] watch, output logic seen, output int passes);
    logic [3:0] prev;
    seen = 1'b0;
    passes = 0;
    prev = col_bcd;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (prev == watch && col_bcd != watch) passes++;
      prev = col_bcd;
      seen = key_valid;
    end
  endtask
  task automatic run_quiet(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (key_valid) hits++;
    end
  endtask
  initial begin
    logic seen;
    int passes, hits, h2, len, bad;
    logic [3:0] exp_col;
    repeat (3) @(negedge clk);
    check("rst_col", col_bcd, 0);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_press", key_press, 0);
    check("rst_map", key_map, 0);
    scan_en = 1'b1;
    reset_n = 1'b1;
    hits = 0;
    len = 0;
    while (col_bcd == 4'd0 && len < 40) begin
      @(negedge clk);
      len++;
      if (key_valid) hits++;
    end
    for (int k = 1; k <= 10; k++) begin
      exp_col = 4'(k % 10);
      check("col_seq", col_bcd, exp_col);
      len = 0;
      while (col_bcd == exp_col && len < 40) begin
        @(negedge clk);
        len++;
        if (key_valid) hits++;
      end
      check("col_hold", len, 18);
    end
    check("idle_no_valid", hits, 0);
    sw[25] = 1'b1;
    wait_valid(800, 4'd5, seen, passes);
    check("make25_seen", seen, 1);
    check("make25_passes", passes, 2);
    check("make25_col", col_bcd, 5);
    check("make25_code", key_code, 8'h25);
    check("make25_press", key_press, 1);
    check("make25_map", key_map[25], 1);
    @(negedge clk);
    check("make25_valid_fall", key_valid, 0);
    sw[25] = 1'b0;
    wait_valid(800, 4'd5, seen, passes);
    check("brk25_seen", seen, 1);
    check("brk25_passes", passes, 2);
    check("brk25_code", key_code, 8'h25);
    check("brk25_press", key_press, 0);
    check("brk25_map", key_map[25], 0);
    sw[17] = 1'b1;
    run_quiet(360, hits);
    sw[17] = 1'b0;
    run_quiet(360, h2);
    hits += h2;
    sw[17] = 1'b1;
    run_quiet(360, h2);
    hits += h2;
    sw[17] = 1'b0;
    run_quiet(180, h2);
    hits += h2;
    check("bounce_no_valid", hits, 0);
    check("bounce_map", key_map, 0);
    key_ready = 1'b0;
    n_make = 0;
    sw[3] = 1'b1;
    sw[13] = 1'b1;
    wait_valid(800, 4'd3, seen, passes);
    check("blk_seen", seen, 1);
    check("blk_code", key_code, 8'h03);
    check("blk_press", key_press, 1);
    check("blk_map3", key_map[3], 1);
    check("blk_map13", key_map[13], 0);
    bad = 0;
    repeat (540) begin
      @(negedge clk);
      if (!key_valid || key_code !== 8'h03 || !key_press) bad++;
    end
    check("blk_hold", bad, 0);
    check("blk_map13_hold", key_map[13], 0);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("blk_accept_fall", key_valid, 0);
    wait_valid(400, 4'd3, seen, passes);
    check("retry_seen", seen, 1);
    check("retry_passes", passes, 0);
    check("retry_code", key_code, 8'h13);
    check("retry_press", key_press, 1);
    check("retry_map13", key_map[13], 1);
    key_ready = 1'b1;
    @(negedge clk);
    run_quiet(360, hits);
    check("retry_quiet", hits, 0);
    check("make_total", n_make, 2);
    len = 0;
    while (col_bcd != 4'd4 && len < 200) begin
      @(negedge clk);
      len++;
    end
    check("frz_reach4", col_bcd, 4);
    repeat (5) @(negedge clk);
    scan_en = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (col_bcd != 4'd4 || key_valid) bad++;
    end
    check("frz_hold", bad, 0);
    scan_en = 1'b1;
    len = 0;
    while (col_bcd == 4'd4 && len < 40) begin
      @(negedge clk);
      len++;
    end
    check("frz_resume_len", len, 19);
    check("frz_resume_col", col_bcd, 5);
    key_ready = 1'b0;
    sw[3] = 1'b0;
    wait_valid(800, 4'd3, seen, passes);
    check("pend_seen", seen, 1);
    check("pend_code", key_code, 8'h03);
    check("pend_press", key_press, 0);
    reset_n = 1'b0;
    #1;
    check("arst_valid", key_valid, 0);
    check("arst_map", key_map, 0);
    check("arst_col", col_bcd, 0);
    check("arst_code", key_code, 0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
